// File: rtl/frame_cfg_pkg.sv
// Shared constants and types for the configuration frame writer.
package frame_cfg_pkg;

  localparam logic [7:0] FRAME_WRITE = 8'hFA;
  localparam logic [7:0] FRAME_END   = 8'hFD;

  localparam int unsigned MARKER_LSB = 24;
  localparam int unsigned MARKER_W   = 8;
  localparam int unsigned COLUMN_LSB = 16;
  localparam int unsigned COLUMN_W   = 8;
  localparam int unsigned FRAME_LSB  = 0;
  localparam int unsigned FRAME_W    = 5;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    DISCARD,
    STROBE,
    GAP
  } state_t;

endpackage

// File: rtl/frame_strobe_decoder.sv
// Column/frame select to one-hot FrameStrobe vector, gated by enable.
module frame_strobe_decoder
  import frame_cfg_pkg::*;
#(
  parameter int unsigned NumColumns      = 16,
  parameter int unsigned MaxFramesPerCol = 20
) (
  input  logic                                  en,
  input  logic [COLUMN_W-1:0]                   column,
  input  logic [FRAME_W-1:0]                    frame,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe
);

  logic [31:0] idx;

  always_comb begin
    idx    = 32'(column) * MaxFramesPerCol + 32'(frame);
    strobe = '0;
    for (int unsigned i = 0; i < NumColumns * MaxFramesPerCol; i++) begin
      strobe[i] = en && (i == idx);
    end
  end

endmodule

// File: rtl/frame_config_writer.sv
// Streams header + NumRows data words into FrameData, then pulses one FrameStrobe bit.
module frame_config_writer
  import frame_cfg_pkg::*;
#(
  parameter int unsigned NumRows         = 16,
  parameter int unsigned NumColumns      = 16,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned StrobeCycles    = 1
) (
  input  logic                                  UserCLK,
  input  logic                                  Reset,
  input  logic [31:0]                           s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  Configured,
  output logic                                  frame_done,
  output logic                                  cmd_err,
  output logic [15:0]                           frames_written
);

  localparam int unsigned RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  state_t                                state, state_next;
  logic [RowW-1:0]                       row;
  logic [3:0]                            scnt;
  logic [COLUMN_W-1:0]                   col_q;
  logic [FRAME_W-1:0]                    frm_q;
  logic                                  ready_q;
  logic                                  accept, last_row, in_range;
  logic                                  cmd_err_next, cfg_set, load_row;
  logic                                  strobe_start, strobe_last;
  logic [MARKER_W-1:0]                   hdr_marker;
  logic [COLUMN_W-1:0]                   hdr_col;
  logic [FRAME_W-1:0]                    hdr_frm;
  logic [NumColumns*MaxFramesPerCol-1:0] dec_strobe;

  assign s_ready    = ready_q;
  assign accept     = s_valid && ready_q;
  assign last_row   = (row == RowW'(NumRows - 1));
  assign hdr_marker = s_data[MARKER_LSB +: MARKER_W];
  assign hdr_col    = s_data[COLUMN_LSB +: COLUMN_W];
  assign hdr_frm    = s_data[FRAME_LSB +: FRAME_W];
  assign in_range   = (32'(hdr_col) < NumColumns) && (32'(hdr_frm) < MaxFramesPerCol);

  always_comb begin
    state_next   = state;
    cmd_err_next = 1'b0;
    cfg_set      = 1'b0;
    load_row     = 1'b0;
    strobe_start = 1'b0;
    strobe_last  = 1'b0;
    case (state)
      HDR: if (accept) begin
        case (hdr_marker)
          FRAME_WRITE: begin
            if (in_range) state_next = LOAD;
            else begin
              cmd_err_next = 1'b1;
              state_next   = DISCARD;
            end
          end
          FRAME_END: cfg_set = 1'b1;
          default:   cmd_err_next = 1'b1;
        endcase
      end
      LOAD: if (accept) begin
        load_row = 1'b1;
        if (last_row) begin
          strobe_start = 1'b1;
          state_next   = STROBE;
        end
      end
      DISCARD: if (accept && last_row) state_next = HDR;
      STROBE: if (scnt == 4'(StrobeCycles - 1)) begin
        strobe_last = 1'b1;
        state_next  = GAP;
      end
      GAP:     state_next = HDR;
      default: state_next = HDR;
    endcase
  end

  // Strobe register is loaded on the final data accept so the pulse starts the next cycle.
  frame_strobe_decoder #(
    .NumColumns     (NumColumns),
    .MaxFramesPerCol(MaxFramesPerCol)
  ) u_dec (
    .en    (strobe_start),
    .column(col_q),
    .frame (frm_q),
    .strobe(dec_strobe)
  );

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state          <= HDR;
      ready_q        <= 1'b0;
      row            <= '0;
      scnt           <= '0;
      col_q          <= '0;
      frm_q          <= '0;
      FrameData      <= '0;
      FrameStrobe    <= '0;
      Configured     <= 1'b0;
      frame_done     <= 1'b0;
      cmd_err        <= 1'b0;
      frames_written <= '0;
    end else begin
      state      <= state_next;
      ready_q    <= (state_next == HDR) || (state_next == LOAD) || (state_next == DISCARD);
      cmd_err    <= cmd_err_next;
      frame_done <= strobe_last;
      if (cfg_set) Configured <= 1'b1;
      if (state == HDR && accept) begin
        col_q <= hdr_col;
        frm_q <= hdr_frm;
        row   <= '0;
      end
      if ((state == LOAD || state == DISCARD) && accept)
        row <= last_row ? '0 : row + 1'b1;
      if (load_row)
        FrameData[row*FrameBitsPerRow +: FrameBitsPerRow] <= s_data[FrameBitsPerRow-1:0];
      if (strobe_start) scnt <= '0;
      else if (state == STROBE) scnt <= scnt + 1'b1;
      if (strobe_start) FrameStrobe <= dec_strobe;
      else if (strobe_last) FrameStrobe <= '0;
      if (strobe_last) frames_written <= frames_written + 16'd1;
    end
  end

endmodule
